fib_stream_gen: RTL and testbench

Parametrised second-order recurrence generator: it emits terms t(k) = t(k-1) + t(k-2) from runtime seeds, one per accepted transfer, on a valid/ready stream. It succeeds the fixed 100-iteration Fibonacci free-runner. It adds runtime sequence length and runtime seeds, which cover Fibonacci, Lucas and arbitrary seeds. It also adds output backpressure, last-term marking, a completion pulse and sticky overflow detection. It sits as a stimulus/data source feeding downstream stream consumers.

---
 rtl/fib_stream_gen.sv | 118 +++++++++++
 tb/tb_fib_stream_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fib_stream_gen.sv
// Second-order recurrence stream source: t(k) = t(k-1) + t(k-2) from runtime seeds,
// one term per accepted valid/ready transfer, with last marking, done pulse and
// sticky wrap detection.
module fib_stream_gen #(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic [W-1:0]  seed0,
  input  logic [W-1:0]  seed1,
  output logic [W-1:0]  y,
  output logic          y_valid,
  input  logic          y_ready,
  output logic          last,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [W-1:0]  y_q, y_d;
  // nxt_q is t(idx+1); nxt_wrap_q marks that it came from a sum with carry-out.
  logic [W-1:0]  nxt_q, nxt_d;
  logic          nxt_wrap_q, nxt_wrap_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;

  logic          is_last;
  logic [W:0]    sum;

  assign is_last = (idx_q == len_q - CW'(1));
  assign sum     = {1'b0, y_q} + {1'b0, nxt_q};

  // Next-state: sequence control, term pair shift and wrap tracking.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    y_d        = y_q;
    nxt_d      = nxt_q;
    nxt_wrap_d = nxt_wrap_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          ovf_d = 1'b0;
          if (len != '0) begin
            state_d    = StRun;
            len_d      = len;
            idx_d      = '0;
            y_d        = seed0;
            nxt_d      = seed1;
            nxt_wrap_d = 1'b0;  // seeds are never flagged
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (y_ready) begin
          if (is_last) begin
            state_d = StIdle;
            done_d  = 1'b1;
            y_d     = '0;
          end else begin
            idx_d      = idx_q + CW'(1);
            y_d        = nxt_q;
            // ovf rises exactly when a wrapped term reaches y.
            ovf_d      = ovf_q | nxt_wrap_q;
            nxt_d      = sum[W-1:0];
            nxt_wrap_d = sum[W];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      idx_q      <= '0;
      y_q        <= '0;
      nxt_q      <= '0;
      nxt_wrap_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      y_q        <= y_d;
      nxt_q      <= nxt_d;
      nxt_wrap_q <= nxt_wrap_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign y       = y_q;
  assign y_valid = (state_q == StRun);
  assign busy    = (state_q == StRun);
  assign last    = (state_q == StRun) && is_last;
  assign done    = done_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_fib_stream_gen.sv
// Directed bench: a W=32 instance for sequencing/backpressure/reset and a W=8
// instance for wrap detection, each checked against a scoreboard queue.
module tb_fib_stream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, y_ready;
  logic [6:0]  len;
  logic [31:0] seed0, seed1, y;
  logic        y_valid, last, busy, done, ovf;

  logic        start8, y_ready8;
  logic [6:0]  len8;
  logic [7:0]  seed0_8, seed1_8, y8;
  logic        y_valid8, last8, busy8, done8, ovf8;

  fib_stream_gen #(.W(32), .CW(7)) u_dut32 (
    .clk(clk), .rst(rst), .start(start), .len(len), .seed0(seed0), .seed1(seed1),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .last(last), .busy(busy),
    .done(done), .ovf(ovf)
  );

  fib_stream_gen #(.W(8), .CW(7)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .len(len8), .seed0(seed0_8), .seed1(seed1_8),
    .y(y8), .y_valid(y_valid8), .y_ready(y_ready8), .last(last8), .busy(busy8),
    .done(done8), .ovf(ovf8)
  );

  typedef struct packed {
    logic [31:0] y;
    logic        last;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // W=32 run: bp selects the 1,0,0 ready pattern, poke_at injects a start mid-run,
  // rst_after aborts via reset after that many transfers (0 = never).
  task automatic run32(input int n, input logic [31:0] s0, input logic [31:0] s1,
                       input bit bp, input int poke_at, input int rst_after);
    logic [31:0] a, b, t, py;
    logic        pl;
    exp_t        e;
    int          cyc, xfers;
    bit          stalled, aborted;
    a = s0;
    b = s1;
    for (int k = 0; k < n; k++) begin
      e.y = a; e.last = (k == n - 1); e.ovf = 1'b0;
      exp_q.push_back(e);
      t = a + b; a = b; b = t;
    end
    start = 1'b1; len = 7'(n); seed0 = s0; seed1 = s1;
    tick();
    start = 1'b0; len = 7'd3; seed0 = $urandom; seed1 = $urandom;
    if (n == 0) begin
      chk("len0_done", 32'(done), 32'd1);
      chk("len0_valid", 32'(y_valid), 32'd0);
      chk("len0_busy", 32'(busy), 32'd0);
      tick();
      chk("len0_done_pulse", 32'(done), 32'd0);
      chk("len0_valid2", 32'(y_valid), 32'd0);
      chk("len0_busy2", 32'(busy), 32'd0);
      return;
    end
    cyc = 0; xfers = 0; stalled = 1'b0; aborted = 1'b0; py = '0; pl = 1'b0;
    while (exp_q.size() != 0 && cyc < 400) begin
      if (rst_after != 0 && xfers == rst_after) begin
        rst = 1'b1; y_ready = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_y", y, 32'd0);
        chk("rst_valid", 32'(y_valid), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        exp_q.delete();
        aborted = 1'b1;
        break;
      end
      y_ready = bp ? (cyc % 3 == 0) : 1'b1;
      start = (cyc == poke_at);
      chk("valid", 32'(y_valid), 32'd1);
      chk("busy", 32'(busy), 32'd1);
      chk("ovf32", 32'(ovf), 32'd0);
      if (stalled) begin
        chk("hold_y", y, py);
        chk("hold_last", 32'(last), 32'(pl));
      end
      if (y_ready) begin
        e = exp_q.pop_front();
        chk("term", y, e.y);
        chk("last", 32'(last), 32'(e.last));
        xfers++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1; py = y; pl = last;
      end
      tick();
      cyc++;
    end
    start = 1'b0; y_ready = 1'b1;
    if (aborted) return;
    if (exp_q.size() != 0) begin
      chk("timeout_pending", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_valid", 32'(y_valid), 32'd0);
    chk("xfers", 32'(xfers), 32'(n));
    if (!bp) chk("no_bubbles", 32'(cyc), 32'(n));
  endtask

  // W=8 run with y_ready held high, checking terms, last and the wrap flag.
  task automatic run8(input int n, input logic [7:0] s0, input logic [7:0] s1);
    logic [7:0] a, b;
    logic [8:0] s;
    logic       aw, bw, ov;
    exp_t       e;
    int         cyc;
    a = s0; b = s1; aw = 1'b0; bw = 1'b0; ov = 1'b0;
    for (int k = 0; k < n; k++) begin
      ov = ov | aw;
      e.y = 32'(a); e.last = (k == n - 1); e.ovf = ov;
      exp_q.push_back(e);
      s = {1'b0, a} + {1'b0, b};
      a = b; aw = bw; b = s[7:0]; bw = s[8];
    end
    start8 = 1'b1; len8 = 7'(n); seed0_8 = s0; seed1_8 = s1; y_ready8 = 1'b1;
    tick();
    start8 = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      e = exp_q.pop_front();
      chk("w8_valid", 32'(y_valid8), 32'd1);
      chk("w8_term", 32'(y8), e.y);
      chk("w8_last", 32'(last8), 32'(e.last));
      chk("w8_ovf", 32'(ovf8), 32'(e.ovf));
      tick();
      cyc++;
    end
    chk("w8_done", 32'(done8), 32'd1);
    chk("w8_valid_end", 32'(y_valid8), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; y_ready = 1'b1; len = '0; seed0 = '0; seed1 = '0;
    start8 = 1'b0; y_ready8 = 1'b1; len8 = '0; seed0_8 = '0; seed1_8 = '0;
    tick();
    tick();
    chk("reset_y", y, 32'd0);
    chk("reset_valid", 32'(y_valid), 32'd0);
    chk("reset_last", 32'(last), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_y8", 32'(y8), 32'd0);
    chk("reset_ovf8", 32'(ovf8), 32'd0);
    rst = 1'b0;
    tick();

    run32(10, 32'd0, 32'd1, 1'b0, -1, 0);   // Fibonacci
    run32(10, 32'd0, 32'd1, 1'b1, -1, 0);   // same under backpressure
    run32(5, 32'd2, 32'd1, 1'b0, -1, 0);    // Lucas
    run32(1, 32'd9, 32'd4, 1'b0, -1, 0);    // single term, restart in done cycle
    run32(0, 32'd5, 32'd6, 1'b0, -1, 0);    // len=0
    run32(20, 32'd3, 32'd7, 1'b0, 5, 0);    // start ignored while busy
    run32(10, 32'd0, 32'd1, 1'b0, -1, 4);   // reset mid-sequence
    run32(10, 32'd0, 32'd1, 1'b0, -1, 0);   // clean restart

    run8(16, 8'd0, 8'd1);
    chk("w8_ovf_sticky", 32'(ovf8), 32'd1);
    run8(3, 8'd5, 8'd6);                    // new start clears ovf

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
